// File: rtl/c2_lm_array_if.sv
// Bus bundle for c2_lm_array: per-lane C2 operands, serial config chain and results.
interface c2_lm_array_if #(
  parameter int LANES = 8
);
  logic             in_valid;
  logic [LANES-1:0] d00, d01, d10, d11;
  logic [LANES-1:0] a1, b1, a0, b0;
  logic             cfg_en;
  logic             cfg_bit;
  logic [LANES-1:0] out;
  logic             out_valid;
  logic             cfg_done;
  logic             busy;

  modport master (
    output in_valid, d00, d01, d10, d11, a1, b1, a0, b0, cfg_en, cfg_bit,
    input  out, out_valid, cfg_done, busy
  );

  modport slave (
    input  in_valid, d00, d01, d10, d11, a1, b1, a0, b0, cfg_en, cfg_bit,
    output out, out_valid, cfg_done, busy
  );
endinterface

// File: rtl/c2_lm_array.sv
// Bank of run-time configurable Actel C2-style logic modules with a serial config
// chain committed atomically and a 0..2 stage registered output pipeline.
module c2_lm_array #(
  parameter int LANES = 8,
  parameter int PIPE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  c2_lm_array_if.slave bus
);

  localparam int N  = 4 * LANES;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t           state;
  logic [N-1:0]     shadow;
  logic [N-1:0]     active;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             cfg_done_q;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      active     <= '0;
      count      <= '0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_en) begin
            shadow <= {shadow[N-2:0], bus.cfg_bit};
            count  <= CW'(1);
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (bus.cfg_en) begin
            shadow <= {shadow[N-2:0], bus.cfg_bit};
            count  <= count + CW'(1);
            if (count == CW'(N - 1)) begin
              cfg_done_q <= 1'b1;
              state      <= COMMIT;
            end
          end else begin
            // Abort: the partial shadow is simply abandoned.
            count  <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        COMMIT: begin
          active <= shadow;
          count  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.cfg_done = cfg_done_q;

  logic [LANES-1:0] sel1, sel0, res;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel1 = '0;
    sel0 = '0;
    res  = '0;
    for (int i = 0; i < LANES; i++) begin
      case (active[4*i+2 +: 2])
        2'b00:   sel1[i] = bus.a1[i] | bus.b1[i];
        2'b01:   sel1[i] = bus.a1[i] & bus.b1[i];
        2'b10:   sel1[i] = bus.a1[i] ^ bus.b1[i];
        default: sel1[i] = bus.a1[i];
      endcase
      case (active[4*i +: 2])
        2'b00:   sel0[i] = bus.a0[i] & bus.b0[i];
        2'b01:   sel0[i] = bus.a0[i] | bus.b0[i];
        2'b10:   sel0[i] = bus.a0[i] ^ bus.b0[i];
        default: sel0[i] = bus.a0[i];
      endcase
      case ({sel1[i], sel0[i]})
        2'b00:   res[i] = bus.d00[i];
        2'b01:   res[i] = bus.d01[i];
        2'b10:   res[i] = bus.d10[i];
        default: res[i] = bus.d11[i];
      endcase
    end
  end

  if (PIPE == 0) begin : g_comb
    assign bus.out       = res;
    assign bus.out_valid = bus.in_valid;
  end else begin : g_pipe
    logic [LANES-1:0] stage_out [PIPE];
    logic             stage_v   [PIPE];

    // NOTE: the pipeline array is reset explicitly because out must read 0 in reset
    // and in-flight samples have to be dropped, not merely flagged invalid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < PIPE; k++) begin
          stage_out[k] <= '0;
          stage_v[k]   <= 1'b0;
        end
      end else begin
        stage_out[0] <= res;
        stage_v[0]   <= bus.in_valid;
        for (int k = 1; k < PIPE; k++) begin
          stage_out[k] <= stage_out[k-1];
          stage_v[k]   <= stage_v[k-1];
        end
      end
    end

    assign bus.out       = stage_out[PIPE-1];
    assign bus.out_valid = stage_v[PIPE-1];
  end

endmodule

// File: doc/c2_lm_array.md
# c2_lm_array

Parametrised, configurable bank of Actel C2-style logic modules for the multiplier datapath. Each lane is a 4:1 mux whose two select lines come from per-lane selectable two-input gate functions. These functions are loaded at run time through a serial configuration chain and committed atomically. Outputs are registered through a parametrised pipeline with a valid flag. After reset every lane behaves as the legacy C2 cell (s1 = a1|b1, s0 = a0&b0).

## Interface

Parameters:
- LANES, 8, number of independent C2 lanes (1..32)
- PIPE, 1, output register stages (0, 1 or 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  data inputs valid this cycle
- d00, d01, d10, d11  input  LANES  mux data inputs, bit i belongs to lane i
- a1, b1, a0, b0  input  LANES  select-gate operands, bit i belongs to lane i
- cfg_en  input  1  serial configuration strobe
- cfg_bit  input  1  serial configuration data
- out  output  LANES  mux result
- out_valid  output  1  out carries a valid result
- cfg_done  output  1  one-cycle pulse when a new configuration is committed
- busy  output  1  configuration load in progress

## Operation

- Per-lane config, active register bits [4i+3:4i] = {s1m[1:0], s0m[1:0]}.
  - s1m: 00 OR, 01 AND, 10 XOR, 11 pass a1.
  - s0m: 00 AND, 01 OR, 10 XOR, 11 pass a0.
- Lane function: out_i = d{s1,s0}_i, with s1 = f(s1m, a1_i, b1_i) and s0 = g(s0m, a0_i, b0_i).
- Config chain length N = 4*LANES.
  - Shadow shifts as shadow <= {shadow[N-2:0], cfg_bit} on each accepted bit.
  - First bit sent lands in the MSB (lane LANES-1, s1m[1]).
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE, cfg_en=1: shift, count=1, go to LOAD. With N=1 impossible (LANES≥1 gives N≥4).
  - LOAD, cfg_en=1: shift, count+1. The shift with count==N-1 goes to COMMIT.
  - LOAD, cfg_en=0: abort. Go to IDLE, count=0, shadow contents don't-care, active config unchanged, no cfg_done.
  - COMMIT: active <= shadow at end of cycle, cfg_done=1, count=0, go to IDLE. cfg_en/cfg_bit are ignored in this state.
- busy = 1 in LOAD and COMMIT, 0 in IDLE.
- The datapath never stalls. Samples are evaluated with the active config in effect in their input cycle.
  - A sample in the COMMIT cycle uses the old config.
  - The first sample using the new config is in the cycle after COMMIT.
- Reset values: active=0 (legacy C2), shadow=0, count=0, state IDLE, out=0, out_valid=0, cfg_done=0, busy=0.
- Reset asserted mid-load or mid-pipeline:
  - All state clears immediately (asynchronous).
  - In-flight samples are dropped.
  - The partial configuration is discarded.

## Timing

- PIPE=0: out and out_valid (= in_valid) are combinational from the inputs.
- PIPE=1: result and valid appear one cycle after the input cycle.
- PIPE=2: result and valid appear two cycles after the input cycle.
- Pipeline registers load out unconditionally. out_valid tracks in_valid through the same stages, so out holds don't-care values when out_valid=0.
- Config: first bit accepted in cycle k, last bit in k+N-1, COMMIT and cfg_done in k+N. New config applies to inputs from k+N+1.
- Back-to-back loads: cfg_en high in k+N is ignored. A new load may begin at k+N+1.
- cfg_done is a Moore output of the COMMIT state and is exactly one cycle wide.

## Test plan

- Reset default, LANES=8, PIPE=1: lane0 a1=0, b1=1, a0=1, b0=1, d11=1, others 0, in_valid=1 -> next cycle out[0]=1, out_valid=1; with b0=0 and d10=1 -> out[0]=1 from d10.
- Load 32 bits of nibble 0101 per lane (s1 AND, s0 OR) starting at cycle k -> busy=1 from k+1 to k+32, cfg_done=1 only at k+32; then a1=0, b1=1, a0=1, b0=0, d01=1 -> out[0]=1 (select 01).
- Abort: cfg_en high for 10 cycles, then low -> busy drops, cfg_done never pulses, legacy behaviour is unchanged.
- Commit boundary: new config is XOR/XOR (nibble 1010); inputs a1=1, b1=1, a0=1, b0=1 with d11=1, d00=0 applied in the COMMIT cycle and the next -> outputs 1 (legacy selects 11), then 0 (XOR selects 00).
- Async reset while in LOAD at count 20 and with a valid sample in the PIPE=2 pipeline -> out, out_valid, busy, cfg_done go 0 without waiting for clk; afterwards legacy C2 behaviour and a full 32-bit load from count 0 succeeds.
- PIPE=0 and PIPE=2 builds: identical stimulus -> identical out values, with latency 0 and 2 cycles respectively.
